// File: rtl/alu_uart_interface.sv
// ---------------------------------------------------------------------------
// alu_uart_interface
//
// Byte-stream sequencer between the UART RX/TX blocks and the combinational
// ALU of the calculator. A frame is operand A, operand B (NB bytes each,
// LSB byte first) followed by one opcode byte. The operands and opcode are
// held on the ALU inputs, the ALU result and zero flag are captured one
// cycle later, and the result is sent back LSB byte first using the
// transmitter's start/done handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   rx_done    one-cycle pulse, rx_data holds a new byte
//   rx_data    received byte
//   alu_result ALU output for the current A, B, select
//   alu_zero   ALU zero flag
//   tx_done    one-cycle pulse, transmitter finished the current byte
//   A, B       operands driven to the ALU
//   select     opcode driven to the ALU
//   tx_start   one-cycle request to transmit tx_data
//   tx_data    byte to transmit, held until tx_done
//   zero_q     zero flag captured with the last result
//   busy       high while computing or transmitting
//   overrun    sticky flag, a byte arrived while busy and was dropped
// ---------------------------------------------------------------------------
module alu_uart_interface #(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done,
   input  logic [7:0]      rx_data,
   input  logic [bits-1:0] alu_result,
   input  logic            alu_zero,
   input  logic            tx_done,
   output logic [bits-1:0] A,
   output logic [bits-1:0] B,
   output logic [3:0]      select,
   output logic            tx_start,
   output logic [7:0]      tx_data,
   output logic            zero_q,
   output logic            busy,
   output logic            overrun
);

   localparam int NB    = (bits + 7) / 8;
   localparam int WW    = 8 * NB;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

   typedef enum logic [2:0] {
      GET_A,
      GET_B,
      GET_OP,
      CALC,
      SEND,
      WAIT_TX
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [bits-1:0]   a_q, a_d;
   logic [bits-1:0]   b_q, b_d;
   logic [3:0]        sel_q, sel_d;
   logic [bits-1:0]   res_q, res_d;
   logic              zero_d;
   logic              tx_start_q, tx_start_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              overrun_q, overrun_d;
   logic              busy_c;

   // Overwrite byte idx of v with b. Works on a byte-padded copy so that
   // bits of the top byte beyond the operand width simply fall off.
   function automatic logic [bits-1:0] put_byte(input logic [bits-1:0]  v,
                                                input logic [CNT_W-1:0] idx,
                                                input logic [7:0]       b);
      logic [WW-1:0]    w;
      logic [CNT_W+2:0] sh;
      sh = {idx, 3'b000};
      w  = WW'(v);
      w  = (w & ~(WW'(8'hFF) << sh)) | (WW'(b) << sh);
      return w[bits-1:0];
   endfunction

   // Byte idx of r, zero-padded above the operand width.
   function automatic logic [7:0] get_byte(input logic [bits-1:0]  r,
                                           input logic [CNT_W-1:0] idx);
      logic [WW-1:0]    w;
      logic [CNT_W+2:0] sh;
      sh = {idx, 3'b000};
      w  = WW'(r) >> sh;
      return w[7:0];
   endfunction

   assign busy_c = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      sel_d      = sel_q;
      res_d      = res_q;
      zero_d     = zero_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      overrun_d  = overrun_q;

      // Bytes arriving mid-computation are dropped, only flagged.
      if (rx_done && busy_c) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         GET_A: begin
            if (rx_done) begin
               a_d = put_byte(a_q, cnt_q, rx_data);
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = GET_B;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         GET_B: begin
            if (rx_done) begin
               b_d = put_byte(b_q, cnt_q, rx_data);
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = GET_OP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         GET_OP: begin
            if (rx_done) begin
               sel_d   = rx_data[3:0];
               state_d = CALC;
            end
         end
         CALC: begin
            // A, B and select have been stable for a full cycle here.
            res_d   = alu_result;
            zero_d  = alu_zero;
            cnt_d   = '0;
            state_d = SEND;
         end
         SEND: begin
            // tx_start/tx_data are registered, so the request appears in
            // the first WAIT_TX cycle.
            tx_start_d = 1'b1;
            tx_data_d  = get_byte(res_q, cnt_q);
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = GET_A;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = SEND;
               end
            end
         end
         default: begin
            state_d = GET_A;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= GET_A;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= '0;
         res_q      <= '0;
         zero_q     <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sel_q      <= sel_d;
         res_q      <= res_d;
         zero_q     <= zero_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         overrun_q  <= overrun_d;
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign select   = sel_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_c;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// ---------------------------------------------------------------------------
// tb_alu_uart_interface
//
// Directed bench for alu_uart_interface. Two instances (8-bit and 16-bit
// operands) share clock and reset; each is wired to a small ALU model and
// driven by byte-level tasks standing in for the UART RX/TX blocks.
// ---------------------------------------------------------------------------
module tb_alu_uart_interface;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 8-bit instance
   logic        rx_done8, tx_done8;
   logic [7:0]  rx_data8;
   logic [7:0]  a8, b8, alu_res8, tx_data8;
   logic [3:0]  sel8;
   logic        alu_zero8, tx_start8, zero8, busy8, ovr8;

   // 16-bit instance
   logic        rx_done16, tx_done16;
   logic [7:0]  rx_data16;
   logic [15:0] a16, b16, alu_res16;
   logic [7:0]  tx_data16;
   logic [3:0]  sel16;
   logic        alu_zero16, tx_start16, zero16, busy16, ovr16;

   int n_tests = 0;
   int n_fail  = 0;

   // Calculator ALU: 0 AND, 1 OR, 2 ADD, 3 SRA (by B), 6 SUB, 7 SLT,
   // 12 NOR, anything else all ones.
   function automatic logic [15:0] alu_model(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [3:0]  s,
                                             input int          w);
      logic [15:0] r;
      logic [15:0] mask;
      mask = (w == 8) ? 16'h00FF : 16'hFFFF;
      case (s)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = (w == 8) ? 16'($signed(a[7:0]) >>> b[3:0])
                             : 16'($signed(a) >>> b[3:0]);
         4'd6:  r = a - b;
         4'd7:  r = (w == 8) ? {15'd0, $signed(a[7:0]) < $signed(b[7:0])}
                             : {15'd0, $signed(a) < $signed(b)};
         4'd12: r = ~(a | b);
         default: r = 16'hFFFF;
      endcase
      return r & mask;
   endfunction

   assign alu_res8   = 8'(alu_model({8'h00, a8}, {8'h00, b8}, sel8, 8));
   assign alu_zero8  = (alu_res8 == 8'h00);
   assign alu_res16  = alu_model(a16, b16, sel16, 16);
   assign alu_zero16 = (alu_res16 == 16'h0000);

   alu_uart_interface #(.bits(8)) dut8 (
      .clk(clk), .reset(reset), .rx_done(rx_done8), .rx_data(rx_data8),
      .alu_result(alu_res8), .alu_zero(alu_zero8), .tx_done(tx_done8),
      .A(a8), .B(b8), .select(sel8), .tx_start(tx_start8), .tx_data(tx_data8),
      .zero_q(zero8), .busy(busy8), .overrun(ovr8)
   );

   alu_uart_interface #(.bits(16)) dut16 (
      .clk(clk), .reset(reset), .rx_done(rx_done16), .rx_data(rx_data16),
      .alu_result(alu_res16), .alu_zero(alu_zero16), .tx_done(tx_done16),
      .A(a16), .B(b16), .select(sel16), .tx_start(tx_start16), .tx_data(tx_data16),
      .zero_q(zero16), .busy(busy16), .overrun(ovr16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One received byte: rx_done high for one cycle, driven on negedge.
   task automatic send_byte(input bit w16, input logic [7:0] b);
      @(negedge clk);
      if (w16) begin
         rx_data16 = b;
         rx_done16 = 1'b1;
      end else begin
         rx_data8 = b;
         rx_done8 = 1'b1;
      end
      @(negedge clk);
      rx_done8  = 1'b0;
      rx_done16 = 1'b0;
   endtask

   task automatic pulse_tx_done(input bit w16);
      if (w16) tx_done16 = 1'b1;
      else     tx_done8  = 1'b1;
      @(negedge clk);
      tx_done8  = 1'b0;
      tx_done16 = 1'b0;
   endtask

   // Wait (bounded) for tx_start, check latency in cycles from the call,
   // the byte, that the pulse is single-cycle and data is held, then
   // acknowledge with tx_done.
   task automatic get_tx(input bit w16, input int exp_lat,
                         input logic [7:0] exp, input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         if (w16 ? tx_start16 : tx_start8) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      check({tag, "_start"}, 32'(seen), 32'd1);
      check({tag, "_lat"},   32'(n),    32'(exp_lat));
      check({tag, "_data"},  32'(w16 ? tx_data16 : tx_data8), 32'(exp));
      repeat (2) @(negedge clk);
      check({tag, "_pulse"}, 32'(w16 ? tx_start16 : tx_start8), 32'd0);
      check({tag, "_hold"},  32'(w16 ? tx_data16 : tx_data8), 32'(exp));
      pulse_tx_done(w16);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                       input logic [7:0] exp, input logic exp_zero, input string tag);
      send_byte(1'b0, a);
      send_byte(1'b0, b);
      send_byte(1'b0, op);
      check({tag, "_A"},    32'(a8),   32'(a));
      check({tag, "_B"},    32'(b8),   32'(b));
      check({tag, "_sel"},  32'(sel8), 32'(op[3:0]));
      check({tag, "_busy"}, 32'(busy8), 32'd1);
      get_tx(1'b0, 2, exp, tag);
      check({tag, "_zero"}, 32'(zero8), 32'(exp_zero));
      check({tag, "_idle"}, 32'(busy8), 32'd0);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      rx_done8  = 1'b0; rx_data8  = 8'h00; tx_done8  = 1'b0;
      rx_done16 = 1'b0; rx_data16 = 8'h00; tx_done16 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_A",       32'(a8),        32'd0);
      check("rst_B",       32'(b8),        32'd0);
      check("rst_sel",     32'(sel8),      32'd0);
      check("rst_txstart", 32'(tx_start8), 32'd0);
      check("rst_txdata",  32'(tx_data8),  32'd0);
      check("rst_zero",    32'(zero8),     32'd0);
      check("rst_ovr",     32'(ovr8),      32'd0);
      check("rst_busy",    32'(busy8),     32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Stray tx_done while idle must not disturb anything.
      pulse_tx_done(1'b0);
      check("stray_txdone_busy", 32'(busy8), 32'd0);

      run8(8'h05, 8'h03, 8'h02, 8'h08, 1'b0, "add");
      check("add_ovr", 32'(ovr8), 32'd0);
      run8(8'h07, 8'h07, 8'h06, 8'h00, 1'b1, "sub_zero");
      run8(8'h07, 8'h07, 8'h02, 8'h0E, 1'b0, "add2");
      run8(8'hF0, 8'h02, 8'h03, 8'hFC, 1'b0, "sra");
      run8(8'h12, 8'h34, 8'h08, 8'hFF, 1'b0, "unused_op");
      check("unused_sel_hold", 32'(sel8), 32'd8);

      // 16-bit operands, two result bytes LSB first.
      send_byte(1'b1, 8'h34);
      send_byte(1'b1, 8'h12);
      send_byte(1'b1, 8'h01);
      send_byte(1'b1, 8'h00);
      send_byte(1'b1, 8'h02);
      check("w16_A",   32'(a16),   32'h1234);
      check("w16_B",   32'(b16),   32'h0001);
      check("w16_sel", 32'(sel16), 32'd2);
      get_tx(1'b1, 2, 8'h35, "w16_b0");
      get_tx(1'b1, 1, 8'h12, "w16_b1");
      check("w16_idle", 32'(busy16), 32'd0);
      check("w16_zero", 32'(zero16), 32'd0);

      // Overrun: byte arrives while waiting on the transmitter.
      send_byte(1'b0, 8'h09);
      send_byte(1'b0, 8'h01);
      send_byte(1'b0, 8'h02);
      n = 0;
      while (!tx_start8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ovr_start", 32'(tx_start8), 32'd1);
      send_byte(1'b0, 8'hAA);
      check("ovr_flag",   32'(ovr8),     32'd1);
      check("ovr_busy",   32'(busy8),    32'd1);
      check("ovr_A_hold", 32'(a8),       32'h09);
      check("ovr_data",   32'(tx_data8), 32'h0A);
      pulse_tx_done(1'b0);
      run8(8'h01, 8'h01, 8'h02, 8'h02, 1'b0, "after_ovr");
      check("ovr_sticky", 32'(ovr8), 32'd1);

      // Asynchronous reset mid-frame.
      send_byte(1'b0, 8'h55);
      check("pre_rst_A", 32'(a8), 32'h55);
      #2 reset = 1'b1;
      #1;
      check("arst_A",    32'(a8),    32'd0);
      check("arst_ovr",  32'(ovr8),  32'd0);
      check("arst_zero", 32'(zero8), 32'd0);
      check("arst_data", 32'(tx_data8), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run8(8'h01, 8'h02, 8'h02, 8'h03, 1'b0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
